// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, header field
// positions and the byte-lane count of a host word.
package loader_pkg;

    localparam int LANES  = 4;
    localparam int NI_MSB = 31;
    localparam int NI_LSB = 16;
    localparam int ND_MSB = 15;
    localparam int ND_LSB = 0;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_HEADER     = 3'd1;
    localparam logic [2:0] ST_INSTR      = 3'd2;
    localparam logic [2:0] ST_DATA_FETCH = 3'd3;
    localparam logic [2:0] ST_DATA_EMIT  = 3'd4;
    localparam logic [2:0] ST_CHECK      = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;
    localparam logic [2:0] ST_ERROR      = 3'd7;

    // Number of valid byte lanes in the next fetched word, given bytes still owed.
    function automatic logic [2:0] lane_fill(input logic [15:0] remaining);
        if (remaining >= 16'(LANES)) begin
            return 3'(LANES);
        end else begin
            return remaining[2:0];
        end
    endfunction

endpackage

// File: rtl/byte_unpacker.sv
// Holds one fetched data word and hands out its valid byte lanes, lowest lane
// first; lanes beyond the fill count are never presented.
module byte_unpacker
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic [2:0]  fill_i,
    input  logic        emit_i,
    output logic [7:0]  byte_o,
    output logic        last_o
);

    logic [31:0]              word_q, word_d;
    logic [$clog2(LANES)-1:0] lane_q, lane_d;
    logic [2:0]               rem_q,  rem_d;

    // Next-state for word register, lane index and remaining-byte count.
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        rem_d  = rem_q;
        if (clear_i) begin
            word_d = 32'd0;
            lane_d = '0;
            rem_d  = 3'd0;
        end else if (load_i) begin
            word_d = word_i;
            lane_d = '0;
            rem_d  = fill_i;
        end else if (emit_i && (rem_q != 3'd0)) begin
            lane_d = lane_q + 1'b1;
            rem_d  = rem_q - 3'd1;
        end else begin
            rem_d  = rem_q;
        end
    end

    // Unpacker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= 32'd0;
            lane_q <= '0;
            rem_q  <= 3'd0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
            rem_q  <= rem_d;
        end
    end

    assign byte_o = word_q[8*lane_q +: 8];
    assign last_o = (rem_q == 3'd1);

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: streams a header, NI instruction words and ND data
// bytes from a host into instruction/data memory write strobes.
// Define LOADER_CHECKSUM_EN to require a modulo-2^32 checksum trailer word.
module program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        host_valid,
    input  logic [31:0] host_data,
    output logic        host_ready,
    output logic        instruction_load,
    output logic [31:0] instruction_store,
    output logic        data_load,
    output logic [7:0]  data_store,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    logic [2:0]  state_q, state_d;
    logic [15:0] ni_q, ni_d, nd_q, nd_d;
    logic [15:0] icnt_q, icnt_d, dcnt_q, dcnt_d;
    logic        il_q, il_d, dl_q, dl_d;
    logic [31:0] is_q, is_d;
    logic [7:0]  ds_q, ds_d;
    logic        hr_q, hr_d, rdy_q, rdy_d, busy_q, busy_d, err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic        xfer_s;
    logic [15:0] hdr_ni_s, hdr_nd_s;
    logic        too_big_s;
    logic        unp_clear_s, unp_load_s, unp_emit_s, unp_last_s;
    logic [7:0]  unp_byte_s;
    logic [2:0]  unp_fill_s;

    assign xfer_s     = host_valid && hr_q;
    assign hdr_ni_s   = host_data[NI_MSB:NI_LSB];
    assign hdr_nd_s   = host_data[ND_MSB:ND_LSB];
    assign too_big_s  = ({16'd0, hdr_ni_s} > 32'(IMEM_WORDS)) ||
                        ({16'd0, hdr_nd_s} > 32'(DMEM_BYTES));
    assign unp_fill_s = lane_fill(nd_q - dcnt_q);

    byte_unpacker u_unpacker (
        .clk     (clk),
        .rst     (rst),
        .clear_i (unp_clear_s),
        .load_i  (unp_load_s),
        .word_i  (host_data),
        .fill_i  (unp_fill_s),
        .emit_i  (unp_emit_s),
        .byte_o  (unp_byte_s),
        .last_o  (unp_last_s)
    );

    // Session FSM: next state, counters, strobes and unpacker control.
    always_comb begin
        state_d     = state_q;
        ni_d        = ni_q;
        nd_d        = nd_q;
        icnt_d      = icnt_q;
        dcnt_d      = dcnt_q;
        il_d        = 1'b0;
        is_d        = is_q;
        dl_d        = 1'b0;
        ds_d        = ds_q;
        unp_clear_s = 1'b0;
        unp_load_s  = 1'b0;
        unp_emit_s  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d     = ST_HEADER;
                    icnt_d      = 16'd0;
                    dcnt_d      = 16'd0;
                    unp_clear_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d       = 32'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_HEADER: begin
                if (xfer_s) begin
                    ni_d = hdr_ni_s;
                    nd_d = hdr_nd_s;
`ifdef LOADER_CHECKSUM_EN
                    sum_d = host_data;
`endif
                    if (too_big_s) begin
                        state_d = ST_ERROR;
                    end else if (hdr_ni_s != 16'd0) begin
                        state_d = ST_INSTR;
                    end else if (hdr_nd_s != 16'd0) begin
                        state_d = ST_DATA_FETCH;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_INSTR: begin
                if (xfer_s) begin
                    il_d   = 1'b1;
                    is_d   = host_data;
                    icnt_d = icnt_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + host_data;
`endif
                    if (icnt_d == ni_q) begin
                        state_d = (nd_q != 16'd0) ? ST_DATA_FETCH : ST_CHECK;
                    end else begin
                        state_d = ST_INSTR;
                    end
                end else begin
                    state_d = ST_INSTR;
                end
            end
            ST_DATA_FETCH: begin
                if (xfer_s) begin
                    unp_load_s = 1'b1;
                    state_d    = ST_DATA_EMIT;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = sum_q + host_data;
`endif
                end else begin
                    state_d = ST_DATA_FETCH;
                end
            end
            ST_DATA_EMIT: begin
                unp_emit_s = 1'b1;
                dl_d       = 1'b1;
                ds_d       = unp_byte_s;
                dcnt_d     = dcnt_q + 16'd1;
                // Stop on the byte count, not the word boundary, so spare lanes are dropped.
                if (dcnt_d == nd_q) begin
                    state_d = ST_CHECK;
                end else if (unp_last_s) begin
                    state_d = ST_DATA_FETCH;
                end else begin
                    state_d = ST_DATA_EMIT;
                end
            end
            ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer_s) begin
                    state_d = (host_data == sum_q) ? ST_DONE : ST_ERROR;
                end else begin
                    state_d = ST_CHECK;
                end
`else
                state_d = ST_DONE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the next state so they are registered yet aligned with the state.
    always_comb begin
        rdy_d  = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERROR);
        busy_d = (state_d == ST_HEADER) || (state_d == ST_INSTR) ||
                 (state_d == ST_DATA_FETCH) || (state_d == ST_DATA_EMIT) ||
                 (state_d == ST_CHECK);
`ifdef LOADER_CHECKSUM_EN
        hr_d   = (state_d == ST_HEADER) || (state_d == ST_INSTR) ||
                 (state_d == ST_DATA_FETCH) || (state_d == ST_CHECK);
`else
        hr_d   = (state_d == ST_HEADER) || (state_d == ST_INSTR) ||
                 (state_d == ST_DATA_FETCH);
`endif
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ni_q    <= 16'd0;
            nd_q    <= 16'd0;
            icnt_q  <= 16'd0;
            dcnt_q  <= 16'd0;
            il_q    <= 1'b0;
            is_q    <= 32'd0;
            dl_q    <= 1'b0;
            ds_q    <= 8'd0;
            hr_q    <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            ni_q    <= ni_d;
            nd_q    <= nd_d;
            icnt_q  <= icnt_d;
            dcnt_q  <= dcnt_d;
            il_q    <= il_d;
            is_q    <= is_d;
            dl_q    <= dl_d;
            ds_q    <= ds_d;
            hr_q    <= hr_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign host_ready        = hr_q;
    assign instruction_load  = il_q;
    assign instruction_store = is_q;
    assign data_load         = dl_q;
    assign data_store        = ds_q;
    assign ready             = rdy_q;
    assign busy              = busy_q;
    assign error             = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; trailer words are sent only
// when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_ready;
    logic        instruction_load;
    logic [31:0] instruction_store;
    logic        data_load;
    logic [7:0]  data_store;
    logic        ready;
    logic        busy;
    logic        error;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          both_cnt = 0;
    logic [31:0] iq[$];
    logic [7:0]  dq[$];
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] tb_sum;
`endif

    always #5 clk = ~clk;

    program_loader #(.IMEM_WORDS(256), .DMEM_BYTES(1024)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .host_valid        (host_valid),
        .host_data         (host_data),
        .host_ready        (host_ready),
        .instruction_load  (instruction_load),
        .instruction_store (instruction_store),
        .data_load         (data_load),
        .data_store        (data_store),
        .ready             (ready),
        .busy              (busy),
        .error             (error)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: record every write just after the clock edge.
    always @(posedge clk) begin
        #1;
        if (instruction_load) iq.push_back(instruction_store);
        if (data_load) dq.push_back(data_store);
        if (instruction_load && data_load) both_cnt++;
    end

    task automatic push_word(input logic [31:0] w);
        int n = 0;
        host_data  = w;
        host_valid = 1'b1;
        while (host_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("push_timeout", {31'd0, host_ready}, 32'd1);
        @(negedge clk);
        host_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        tb_sum = tb_sum + w;
`endif
    endtask

    task automatic start_session();
        iq.delete();
        dq.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        tb_sum = 32'd0;
`endif
    endtask

    task automatic send_trailer(input logic [31:0] delta);
`ifdef LOADER_CHECKSUM_EN
        push_word(tb_sum + delta);
`else
        host_data = host_data ^ (delta & 32'd0);
`endif
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (ready !== 1'b1 && error !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, ready | error}, 32'd1);
    endtask

    task automatic run_basic(input string p);
        logic [7:0] exp_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        start_session();
        push_word(32'h0002_0005);
        push_word(32'h2008_0001);
        push_word(32'h2009_0002);
        push_word(32'h4433_2211);
        push_word(32'h0000_0055);
        send_trailer(32'd0);
        wait_end({p, "_end"});
        check_eq({p, "_ni"}, iq.size(), 32'd2);
        check_eq({p, "_i0"}, iq[0], 32'h2008_0001);
        check_eq({p, "_i1"}, iq[1], 32'h2009_0002);
        check_eq({p, "_nd"}, dq.size(), 32'd5);
        for (int i = 0; i < 5; i++) check_eq($sformatf("%s_d%0d", p, i), {24'd0, dq[i]}, {24'd0, exp_b[i]});
        check_eq({p, "_status"}, {29'd0, ready, busy, error}, 32'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bad_hdr[2] = '{32'h0101_0000, 32'h0000_0401};
        logic [7:0]  part_b[6]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        int          n;

        rst = 1'b1; start = 1'b0; host_valid = 1'b0; host_data = 32'd0;
        #1;
        check_eq("rst_ctl", {26'd0, host_ready, instruction_load, data_load, ready, busy, error}, 32'd0);
        check_eq("rst_is", instruction_store, 32'd0);
        check_eq("rst_ds", {24'd0, data_store}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic load with instructions and a two-word data payload
        run_basic("basic");

        // Restart from DONE with an empty program
        start_session();
        check_eq("restart_ready", {30'd0, ready, busy}, 32'b01);
        push_word(32'h0000_0000);
        send_trailer(32'd0);
        n = 0;
        while (ready !== 1'b1 && n < 3) begin
            @(negedge clk);
            n++;
        end
        check_eq("empty_ready", {31'd0, ready}, 32'd1);
        check_eq("empty_strobes", iq.size() + dq.size(), 32'd0);

        // Oversized headers must abort with no strobes
        for (int k = 0; k < 2; k++) begin
            start_session();
            push_word(bad_hdr[k]);
            wait_end($sformatf("oversize%0d_end", k));
            check_eq($sformatf("oversize%0d_status", k), {29'd0, ready, busy, error}, 32'b001);
            check_eq($sformatf("oversize%0d_strobes", k), iq.size() + dq.size(), 32'd0);
        end

        // host_valid stall in the middle of the instruction stream
        start_session();
        push_word(32'h0003_0000);
        push_word(32'h1111_1111);
        repeat (5) @(negedge clk);
        check_eq("stall_count", iq.size() + dq.size(), 32'd1);
        push_word(32'h2222_2222);
        push_word(32'h3333_3333);
        send_trailer(32'd0);
        wait_end("stall_end");
        check_eq("stall_n", iq.size(), 32'd3);
        check_eq("stall_i0", iq[0], 32'h1111_1111);
        check_eq("stall_i1", iq[1], 32'h2222_2222);
        check_eq("stall_i2", iq[2], 32'h3333_3333);
        check_eq("stall_ready", {31'd0, ready}, 32'd1);

        // Six data bytes: the last word's upper two lanes must be dropped
        start_session();
        push_word(32'h0000_0006);
        push_word(32'h0403_0201);
        push_word(32'hFFFF_0605);
        send_trailer(32'd0);
        wait_end("part_end");
        check_eq("part_nd", dq.size(), 32'd6);
        for (int i = 0; i < 6; i++) check_eq($sformatf("part_d%0d", i), {24'd0, dq[i]}, {24'd0, part_b[i]});
        repeat (3) @(negedge clk);
        check_eq("part_no_extra", dq.size() + iq.size(), 32'd6);

        // Asynchronous reset between the second and third data bytes
        start_session();
        push_word(32'h0000_0008);
        push_word(32'hDDCC_BBAA);
        n = 0;
        while (dq.size() < 2 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ctl", {26'd0, host_ready, instruction_load, data_load, ready, busy, error}, 32'd0);
        check_eq("mid_rst_ds", {24'd0, data_store}, 32'd0);
        check_eq("mid_rst_bytes", dq.size(), 32'd2);
        check_eq("mid_rst_b1", {24'd0, dq[1]}, 32'h0000_00BB);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("post_rst_quiet", dq.size() + iq.size(), 32'd2);
        check_eq("post_rst_idle", {29'd0, ready, busy, error}, 32'd0);
        run_basic("reload");

`ifdef LOADER_CHECKSUM_EN
        // Trailer one greater than the true sum
        start_session();
        push_word(32'h0001_0001);
        push_word(32'hAABB_CCDD);
        push_word(32'h0000_00EE);
        send_trailer(32'd1);
        wait_end("badsum_end");
        check_eq("badsum_status", {29'd0, ready, busy, error}, 32'b001);
        check_eq("badsum_i0", iq[0], 32'hAABB_CCDD);
        check_eq("badsum_d0", {24'd0, dq[0]}, 32'h0000_00EE);
`endif

        check_eq("exclusive_strobes", both_cnt, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
